// File: rtl/register_file_mp.sv
// register_file_mp: multi-port register file with write bypass, busy scoreboard and post-reset clear sweep
module register_file_mp #(
  parameter int DATA_W = 32,
  parameter int DEPTH = 32,
  parameter int NUM_READ = 2,
  parameter int NUM_WRITE = 2,
  parameter bit BYPASS = 1'b1,
  parameter bit ZERO_REG = 1'b1,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic                        Clk,
  input  logic                        Reset,
  input  logic [NUM_READ*ADDR_W-1:0]  RdAddr,
  output logic [NUM_READ*DATA_W-1:0]  RdData,
  output logic [NUM_READ-1:0]         RdBusy,
  input  logic [NUM_WRITE-1:0]        WrEn,
  input  logic [NUM_WRITE*ADDR_W-1:0] WrAddr,
  input  logic [NUM_WRITE*DATA_W-1:0] WrData,
  input  logic                        Reserve,
  input  logic [ADDR_W-1:0]           ReserveAddr,
  output logic                        Ready
);
  typedef enum logic {CLEAR, RUN} stateT;
  stateT state, nextState;
  logic [ADDR_W-1:0] ptr;
  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0] busy;
  logic running, resOk;
  logic [NUM_WRITE-1:0] wrOk;
  always_ff @(posedge Clk)
    if (Reset) begin
      state <= CLEAR;
      ptr <= '0;
    end else begin
      state <= nextState;
      ptr <= (state == CLEAR) ? ptr + 1'b1 : ptr;
    end
  always_comb begin
    Ready = (state == RUN);
    nextState = (state == CLEAR && ptr == ADDR_W'(DEPTH - 1)) ? RUN : state;
    running = (state == RUN) && !Reset;
    resOk = running && Reserve && !(ZERO_REG && ReserveAddr == '0);
    wrOk = '0;
    for (int p = 0; p < NUM_WRITE; p++)
      wrOk[p] = running && WrEn[p] && !(ZERO_REG && WrAddr[p*ADDR_W +: ADDR_W] == '0);
  end
  // Storage has no reset of its own; the sweep zeroes it one entry per cycle.
  always_ff @(posedge Clk)
    if (!Reset && state == CLEAR)
      regs[ptr] <= '0;
    else
      for (int p = 0; p < NUM_WRITE; p++)
        if (wrOk[p]) regs[WrAddr[p*ADDR_W +: ADDR_W]] <= WrData[p*DATA_W +: DATA_W];
  // Reserve is applied after the write clears so a new producer keeps the bit set.
  always_ff @(posedge Clk)
    if (Reset)
      busy <= '0;
    else begin
      for (int p = 0; p < NUM_WRITE; p++)
        if (wrOk[p]) busy[WrAddr[p*ADDR_W +: ADDR_W]] <= 1'b0;
      if (resOk) busy[ReserveAddr] <= 1'b1;
    end
  always_comb begin
    RdData = '0;
    RdBusy = '0;
    for (int i = 0; i < NUM_READ; i++) begin
      RdData[i*DATA_W +: DATA_W] = regs[RdAddr[i*ADDR_W +: ADDR_W]];
      RdBusy[i] = busy[RdAddr[i*ADDR_W +: ADDR_W]];
      for (int p = 0; p < NUM_WRITE; p++)
        if (BYPASS && wrOk[p] && WrAddr[p*ADDR_W +: ADDR_W] == RdAddr[i*ADDR_W +: ADDR_W]) begin
          RdData[i*DATA_W +: DATA_W] = WrData[p*DATA_W +: DATA_W];
          RdBusy[i] = resOk && ReserveAddr == RdAddr[i*ADDR_W +: ADDR_W];
        end
      if (state == CLEAR || (ZERO_REG && RdAddr[i*ADDR_W +: ADDR_W] == '0)) begin
        RdData[i*DATA_W +: DATA_W] = '0;
        RdBusy[i] = 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_register_file_mp.sv
// tb_register_file_mp: directed and random checks of register_file_mp against a behavioural model
module tb_register_file_mp;
  localparam int DW = 32, D = 32, AW = 5, NR = 2, NW = 2;
  logic Clk = 1'b0;
  logic Reset;
  logic [NR*AW-1:0] RdAddr;
  logic [NR*DW-1:0] RdData;
  logic [NR-1:0] RdBusy;
  logic [NW-1:0] WrEn;
  logic [NW*AW-1:0] WrAddr;
  logic [NW*DW-1:0] WrData;
  logic Reserve;
  logic [AW-1:0] ReserveAddr;
  logic Ready;
  always #5 Clk = ~Clk;
  register_file_mp dut (
    .Clk(Clk), .Reset(Reset), .RdAddr(RdAddr), .RdData(RdData), .RdBusy(RdBusy),
    .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData), .Reserve(Reserve),
    .ReserveAddr(ReserveAddr), .Ready(Ready)
  );
  logic [DW-1:0] memM [D];
  logic [D-1:0] busyM;
  int sweepM;
  bit readyM, validM;
  int checks = 0, errors = 0;
  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic idle();
    WrEn = '0;
    Reserve = 1'b0;
    Reset = 1'b0;
  endtask
  task automatic wr(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d);
    WrEn[p] = 1'b1;
    WrAddr[p*AW +: AW] = a;
    WrData[p*DW +: DW] = d;
  endtask
  task automatic randomize_inputs(input int maxAddr);
    WrEn = 2'($urandom);
    for (int p = 0; p < NW; p++) begin
      WrAddr[p*AW +: AW] = 5'($urandom_range(0, maxAddr));
      WrData[p*DW +: DW] = $urandom;
    end
    Reserve = 1'($urandom);
    ReserveAddr = 5'($urandom_range(0, maxAddr));
    for (int i = 0; i < NR; i++) RdAddr[i*AW +: AW] = 5'($urandom_range(0, maxAddr));
  endtask
  // Checks the current outputs against the model, then advances model and DUT by one edge.
  task automatic cycle();
    logic [AW-1:0] a;
    logic [DW-1:0] ed;
    logic eb;
    #1;
    if (validM) begin
      check("ready", 32'(Ready), 32'(readyM));
      for (int i = 0; i < NR; i++) begin
        a = RdAddr[i*AW +: AW];
        ed = readyM ? memM[a] : '0;
        eb = readyM ? busyM[a] : 1'b0;
        if (readyM && !Reset)
          for (int p = 0; p < NW; p++)
            if (WrEn[p] && WrAddr[p*AW +: AW] == a) begin
              ed = WrData[p*DW +: DW];
              eb = Reserve && ReserveAddr == a;
            end
        if (a == 0) begin
          ed = '0;
          eb = 1'b0;
        end
        check($sformatf("rddata%0d@%0d", i, a), RdData[i*DW +: DW], ed);
        check($sformatf("rdbusy%0d@%0d", i, a), 32'(RdBusy[i]), 32'(eb));
      end
    end
    @(posedge Clk);
    if (Reset) begin
      readyM = 1'b0;
      sweepM = 0;
      busyM = '0;
      validM = 1'b1;
    end else if (validM && !readyM) begin
      memM[sweepM] = '0;
      sweepM++;
      if (sweepM == D) readyM = 1'b1;
    end else if (readyM) begin
      for (int p = 0; p < NW; p++)
        if (WrEn[p] && WrAddr[p*AW +: AW] != 0) begin
          memM[WrAddr[p*AW +: AW]] = WrData[p*DW +: DW];
          busyM[WrAddr[p*AW +: AW]] = 1'b0;
        end
      if (Reserve && ReserveAddr != 0) busyM[ReserveAddr] = 1'b1;
    end
    @(negedge Clk);
  endtask
  initial begin
    Reset = 1'b1;
    WrEn = '0;
    WrAddr = '0;
    WrData = '0;
    Reserve = 1'b0;
    ReserveAddr = '0;
    RdAddr = '0;
    validM = 1'b0;
    readyM = 1'b0;
    sweepM = 0;
    busyM = '0;
    for (int k = 0; k < D; k++) memM[k] = '0;
    cycle();
    idle();
    for (int k = 0; k < D; k++) begin
      RdAddr = 10'($urandom);
      #1 check("t1 sweep ready low", 32'(Ready), 32'd0);
      cycle();
    end
    #1 check("t1 ready high", 32'(Ready), 32'd1);
    for (int k = 0; k < D / 2; k++) begin
      RdAddr = {5'(2 * k + 1), 5'(2 * k)};
      #1 check("t1 cleared", RdData, 64'd0);
      cycle();
    end
    wr(0, 5, 32'hDEADBEEF);
    RdAddr = {5'd0, 5'd5};
    #1 check("t2 bypass", RdData[31:0], 32'hDEADBEEF);
    cycle();
    idle();
    #1 check("t2 stored", RdData[31:0], 32'hDEADBEEF);
    cycle();
    wr(0, 7, 32'h11);
    wr(1, 7, 32'h22);
    cycle();
    idle();
    RdAddr = {5'd7, 5'd7};
    #1 check("t3 port1 wins", RdData[63:32], 32'h22);
    cycle();
    Reserve = 1'b1;
    ReserveAddr = 5'd9;
    RdAddr = {5'd0, 5'd9};
    cycle();
    idle();
    #1 check("t4 reserved busy", 32'(RdBusy[0]), 32'd1);
    cycle();
    wr(0, 9, 32'h55);
    cycle();
    idle();
    #1 check("t4 write clears busy", 32'(RdBusy[0]), 32'd0);
    check("t4 write data", RdData[31:0], 32'h55);
    cycle();
    wr(1, 9, 32'h66);
    Reserve = 1'b1;
    ReserveAddr = 5'd9;
    cycle();
    idle();
    #1 check("t4 reserve+write busy", 32'(RdBusy[0]), 32'd1);
    check("t4 reserve+write data", RdData[31:0], 32'h66);
    cycle();
    wr(0, 0, 32'hFFFFFFFF);
    Reserve = 1'b1;
    ReserveAddr = 5'd0;
    RdAddr = {5'd0, 5'd0};
    #1 check("t5 zero bypass", RdData[31:0], 32'd0);
    cycle();
    idle();
    #1 check("t5 zero data", RdData, 64'd0);
    check("t5 zero busy", 32'(RdBusy), 32'd0);
    cycle();
    wr(0, 20, 32'hAB);
    cycle();
    idle();
    RdAddr = {5'd0, 5'd20};
    #1 check("t6 reg20 written", RdData[31:0], 32'hAB);
    cycle();
    Reset = 1'b1;
    cycle();
    idle();
    for (int k = 0; k < 10; k++) begin
      randomize_inputs(31);
      cycle();
    end
    idle();
    Reset = 1'b1;
    cycle();
    Reset = 1'b0;
    for (int k = 0; k < D; k++) begin
      randomize_inputs(31);
      WrEn = 2'b11;
      WrAddr = {5'd20, 5'd20};
      #1 check("t6 restart ready low", 32'(Ready), 32'd0);
      cycle();
    end
    idle();
    RdAddr = {5'd0, 5'd20};
    #1 check("t6 reg20 cleared", RdData[31:0], 32'd0);
    check("t6 ready again", 32'(Ready), 32'd1);
    cycle();
    for (int k = 0; k < 400; k++) begin
      randomize_inputs((k % 2 == 0) ? 7 : 31);
      cycle();
    end
    idle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
